// File: rtl/krnl_partialknn_local_sp_reader.sv
// -----------------------------------------------------------------------------
// krnl_partialknn_local_sp_reader
//
// Read-side initiator for a single-port local URAM buffer. On start it walks
// len consecutive words from base_addr (address wraps at AddressRange). It
// absorbs the fixed memory read latency and streams the words out on a
// valid/ready interface with backpressure.
//
// Reads are credit limited: a read is only issued while the words in flight,
// buffered in the skid FIFO and held in the output register number fewer
// than FifoDepth. A word accepted downstream in the same cycle frees its
// credit immediately, so m_ready held high sustains one word per cycle.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   start, base_addr,    transfer request; base_addr and len are sampled with
//   len                  start in IDLE only
//   busy, done           transfer in progress / one-cycle completion pulse
//   address0, ce0,       memory port (write side tied off)
//   we0, d0, q0
//   m_data, m_valid,     output stream; m_last marks the final word
//   m_ready, m_last
// -----------------------------------------------------------------------------
module krnl_partialknn_local_sp_reader #(
    parameter int DataWidth    = 256,
    parameter int AddressWidth = 11,
    parameter int AddressRange = 2048,
    parameter int ReadLatency  = 2,
    parameter int FifoDepth    = ReadLatency + 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [AddressWidth-1:0] base_addr,
    input  logic [AddressWidth:0]   len,
    output logic                    busy,
    output logic                    done,
    output logic [AddressWidth-1:0] address0,
    output logic                    ce0,
    output logic                    we0,
    output logic [DataWidth-1:0]    d0,
    input  logic [DataWidth-1:0]    q0,
    output logic [DataWidth-1:0]    m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last
);

    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW = $clog2(FifoDepth + 1);
    localparam int CrW  = $clog2(FifoDepth + ReadLatency + 2) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [AddressWidth-1:0] cur_addr;
    logic [AddressWidth:0]   remaining;
    logic [ReadLatency-1:0]  vld_sr;
    logic [ReadLatency-1:0]  last_sr;
    logic                    zero_pend;

    logic [DataWidth-1:0]    fifo_data [FifoDepth];
    logic [FifoDepth-1:0]    fifo_last;
    logic [PtrW-1:0]         wr_ptr, rd_ptr;
    logic [CntW-1:0]         fifo_cnt;

    logic                    accept, accept_zero, hs, push, pop, issue, finish;
    logic [CrW-1:0]          outstanding;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [AddressWidth-1:0] addr_inc(input logic [AddressWidth-1:0] a);
        return (a == AddressWidth'(AddressRange - 1)) ? '0 : a + 1'b1;
    endfunction

    assign we0 = 1'b0;
    assign d0  = '0;

    assign accept      = (state == IDLE) && start && (len != '0);
    assign accept_zero = (state == IDLE) && start && (len == '0);
    assign hs          = m_valid && m_ready;
    assign push        = vld_sr[ReadLatency-1];
    assign pop         = (fifo_cnt != '0) && (!m_valid || m_ready);
    assign finish      = (state == DRAIN) && hs && m_last;

    // Words owned by this block: in flight, buffered, and in the output register.
    always_comb begin
        outstanding = CrW'(fifo_cnt) + CrW'(m_valid);
        for (int i = 0; i < ReadLatency; i++) begin
            outstanding = outstanding + CrW'(vld_sr[i]);
        end
    end

    assign issue = (state == READ) && ((outstanding - CrW'(hs)) < CrW'(FifoDepth));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = READ;
            READ:    if (issue && (remaining == (AddressWidth + 1)'(1))) state_nxt = DRAIN;
            DRAIN:   if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            zero_pend <= 1'b0;
            ce0       <= 1'b0;
            address0  <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            vld_sr    <= '0;
            last_sr   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
        end else begin
            state     <= state_nxt;
            zero_pend <= accept_zero;
            done      <= finish || zero_pend;

            if (accept) begin
                busy      <= 1'b1;
                cur_addr  <= base_addr;
                remaining <= len;
            end else if (finish) begin
                busy <= 1'b0;
            end

            // Issue stage: one read per credit.
            ce0 <= issue;
            if (issue) begin
                address0  <= cur_addr;
                cur_addr  <= addr_inc(cur_addr);
                remaining <= remaining - 1'b1;
            end

            // Latency stage: tags march alongside the memory pipeline.
            vld_sr[0]  <= issue;
            last_sr[0] <= issue && (remaining == (AddressWidth + 1)'(1));
            for (int i = 1; i < ReadLatency; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end

            // Skid FIFO stage.
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            fifo_cnt <= fifo_cnt + CntW'(push) - CntW'(pop);

            // Output stage: reload only when empty or being accepted.
            if (!m_valid || m_ready) begin
                m_valid <= (fifo_cnt != '0);
                if (fifo_cnt != '0) begin
                    m_data <= fifo_data[rd_ptr];
                    m_last <= fifo_last[rd_ptr];
                end
            end
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by the control above.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= q0;
            fifo_last[wr_ptr] <= last_sr[ReadLatency-1];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && (fifo_cnt == CntW'(FifoDepth))));

endmodule

// File: tb/tb_krnl_partialknn_local_sp_reader.sv
module tb_krnl_partialknn_local_sp_reader;

    localparam int DW = 256;
    localparam int AW = 11;
    localparam int AR = 2048;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, ce0, we0, m_valid, m_last;
    logic [AW-1:0] address0;
    logic [DW-1:0] d0, q0, m_data;
    logic          m_ready = 1'b1;

    krnl_partialknn_local_sp_reader #(
        .DataWidth(DW), .AddressWidth(AW), .AddressRange(AR), .ReadLatency(2), .FifoDepth(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .address0(address0), .ce0(ce0), .we0(we0), .d0(d0),
        .q0(q0), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // Memory model, read latency 2: address registered with ce0, q0 one cycle later.
    logic [DW-1:0] mem [AR];
    logic [DW-1:0] q_reg;
    always @(posedge clk) if (ce0) q_reg <= mem[address0];
    assign q0 = q_reg;

    function automatic logic [DW-1:0] word(input int a);
        return {8{32'(a) ^ 32'h5A000000}};
    endfunction

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // m_ready driver: mode 0 always ready, mode 1 random with optional forced stall.
    int rdy_mode = 0;
    int rdy_hold = 0;
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) m_ready = 1'b1;
        else if (rdy_hold > 0) begin
            m_ready = 1'b0;
            rdy_hold--;
        end else m_ready = 1'($urandom_range(0, 1));
    end

    // Monitor
    logic [DW-1:0] beat_q [$];
    bit            last_q [$];
    logic [AW-1:0] addr_q [$];
    int ce_cnt, acc_cnt, done_cnt, done_cyc, first_ce, first_vld, max_out, vld_cnt, stab_err;
    bit busy_seen, prev_stall;
    logic [DW-1:0] prev_data;
    logic prev_last;

    task automatic clear_mon();
        beat_q.delete(); last_q.delete(); addr_q.delete();
        ce_cnt = 0; acc_cnt = 0; done_cnt = 0; done_cyc = -1; first_ce = -1;
        first_vld = -1; max_out = 0; vld_cnt = 0; stab_err = 0; busy_seen = 0; prev_stall = 0;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (ce0) begin
                ce_cnt++;
                addr_q.push_back(address0);
                if (first_ce < 0) first_ce = cyc;
            end
            if (m_valid) begin
                vld_cnt++;
                if (first_vld < 0) first_vld = cyc;
            end
            if (ce_cnt - acc_cnt > max_out) max_out = ce_cnt - acc_cnt;
            if (prev_stall && (m_data !== prev_data || m_last !== prev_last)) stab_err++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_valid && m_ready) begin
                beat_q.push_back(m_data);
                last_q.push_back(m_last);
                acc_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_seen = 1;
        end
    end

    int t_start;

    task automatic run_xfer(input int b, input int l);
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(b); len = (AW + 1)'(l);
        t_start = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        repeat (6) @(posedge clk);
        #2;
    endtask

    task automatic chk_stream(input string tag, input int b, input int l);
        int derr = 0, lerr = 0;
        chk_val({tag, "_beats"}, DW'(beat_q.size()), DW'(l));
        for (int i = 0; i < beat_q.size(); i++) begin
            if (beat_q[i] !== word((b + i) % AR)) derr++;
            if (last_q[i] !== (i == l - 1)) lerr++;
        end
        chk_val({tag, "_data_errs"}, DW'(derr), '0);
        chk_val({tag, "_last_errs"}, DW'(lerr), '0);
        chk_val({tag, "_done_cnt"}, DW'(done_cnt), DW'(1));
    endtask

    initial begin
        int a, b, aerr;
        for (int i = 0; i < AR; i++) mem[i] = word(i);
        clear_mon();
        repeat (3) @(posedge clk);
        #2;
        chk_val("rst_busy", DW'(busy), '0);
        chk_val("rst_done", DW'(done), '0);
        chk_val("rst_ce0", DW'(ce0), '0);
        chk_val("rst_addr", DW'(address0), '0);
        chk_val("rst_we0", DW'(we0), '0);
        chk_val("rst_d0", d0, '0);
        chk_val("rst_mvalid", DW'(m_valid), '0);
        chk_val("rst_mdata", m_data, '0);
        chk_val("rst_mlast", DW'(m_last), '0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic read
        run_xfer(4, 8);
        wait_done(60);
        chk_stream("basic", 4, 8);
        chk_val("basic_first_ce", DW'(first_ce), DW'(t_start + 1));
        chk_val("basic_first_vld", DW'(first_vld), DW'(t_start + 4));
        chk_val("basic_done_cyc", DW'(done_cyc), DW'(t_start + 12));
        chk_val("basic_ce_cnt", DW'(ce_cnt), DW'(8));
        chk_val("basic_vld_cnt", DW'(vld_cnt), DW'(8));
        chk_val("basic_busy_end", DW'(busy), '0);

        // Wrap-around
        run_xfer(2044, 8);
        wait_done(60);
        chk_stream("wrap", 2044, 8);
        aerr = 0;
        for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== AW'((2044 + i) % AR)) aerr++;
        chk_val("wrap_addr_errs", DW'(aerr), '0);
        chk_val("wrap_addr_cnt", DW'(addr_q.size()), DW'(8));

        // Backpressure
        rdy_mode = 1;
        run_xfer(100, 32);
        repeat (6) @(posedge clk);
        #2 rdy_hold = 10;
        repeat (6) @(posedge clk);
        #2 a = ce_cnt;
        repeat (4) @(posedge clk);
        #2 b = ce_cnt;
        chk_val("bp_ce_stall", DW'(b - a), '0);
        wait_done(600);
        chk_stream("bp", 100, 32);
        chk_val("bp_max_out_ok", DW'(max_out <= 4), DW'(1));
        chk_val("bp_ce_cnt", DW'(ce_cnt), DW'(32));
        chk_val("bp_stable", DW'(stab_err), '0);
        rdy_mode = 0;
        repeat (2) @(posedge clk);

        // Zero length
        run_xfer(7, 0);
        wait_done(20);
        chk_val("zero_done_cnt", DW'(done_cnt), DW'(1));
        chk_val("zero_done_cyc", DW'(done_cyc), DW'(t_start + 1));
        chk_val("zero_ce_cnt", DW'(ce_cnt), '0);
        chk_val("zero_vld_cnt", DW'(vld_cnt), '0);
        chk_val("zero_busy", DW'(busy_seen), '0);

        // Full range with an ignored start mid-transfer
        run_xfer(0, 2048);
        repeat (500) @(posedge clk);
        #1 start = 1'b1; base_addr = AW'(33); len = (AW + 1)'(5);
        @(posedge clk); #1 start = 1'b0;
        wait_done(2200);
        repeat (20) @(posedge clk);
        #2;
        chk_stream("full", 0, 2048);
        chk_val("full_ce_cnt", DW'(ce_cnt), DW'(2048));

        // Reset abort
        run_xfer(200, 20);
        a = 0;
        while (acc_cnt < 5 && a < 50) begin
            @(posedge clk); #2;
            a++;
        end
        chk_val("abort_reached5", DW'(acc_cnt >= 5), DW'(1));
        reset_n = 1'b0;
        #1;
        chk_val("abort_busy", DW'(busy), '0);
        chk_val("abort_ce0", DW'(ce0), '0);
        chk_val("abort_mvalid", DW'(m_valid), '0);
        chk_val("abort_mdata", m_data, '0);
        chk_val("abort_addr", DW'(address0), '0);
        chk_val("abort_mlast", DW'(m_last), '0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        run_xfer(50, 3);
        wait_done(40);
        repeat (10) @(posedge clk);
        #2;
        chk_stream("after_abort", 50, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
